shift_sequencer: RTL and testbench

Multi-cycle shift controller for the EX stage. It accepts one shift request and walks the log-stage shifter network one stage per clock, from the 16-bit stage down to the 1-bit stage. Each stage is enabled only when the matching shamt bit is set. It raises busy so the hazard unit can stall the pipeline, then returns the result with a one-cycle done pulse. This replaces the flat combinational barrel path, to relieve EX-stage timing.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_stage_n.sv | 39 +++
 rtl/shift_sequencer.sv | 110 +++++++++++
 tb/tb_shift_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: operation codes,
// FSM state encoding and default geometry.
package shift_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SHAMT_W = 5;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROR = 2'b11
   } shift_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } seq_state_e;

   // Width of the stage counter that walks SHAMT_W-1 down to 0.
   function automatic int stage_cnt_w(input int shamt_w);
      return (shamt_w > 1) ? $clog2(shamt_w) : 1;
   endfunction

endpackage

// File: rtl/shift_stage_n.sv
// One stage of the log shifter network: shifts/rotates by the constant N
// when enabled, otherwise passes the data through untouched.
module shift_stage_n
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             en_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] sll_w;
   logic [WIDTH-1:0] srl_w;
   logic [WIDTH-1:0] sra_w;
   logic [WIDTH-1:0] ror_w;

   assign sll_w = data_i << N;
   assign srl_w = data_i >> N;
   // Arithmetic shift replicates the current sign bit of the accumulator.
   assign sra_w = $unsigned($signed(data_i) >>> N);
   assign ror_w = (data_i >> N) | (data_i << (WIDTH - N));

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         case (op_i)
            SH_SLL:  data_o = sll_w;
            SH_SRL:  data_o = srl_w;
            SH_SRA:  data_o = sra_w;
            SH_ROR:  data_o = ror_w;
            default: data_o = data_i;
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: walks the log stages from 2^(SHAMT_W-1) down to 1,
// one per clock, holding busy high and pulsing done with the final result.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SHAMT_W    = DEF_SHAMT_W,
   parameter int EARLY_EXIT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output seq_state_e         state_dbg
);

   localparam int STG_W = stage_cnt_w(SHAMT_W);

   seq_state_e         state_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   acc_d;
   logic [SHAMT_W-1:0] shamt_q;
   logic [1:0]         op_q;
   logic [STG_W-1:0]   stage_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;

   logic [WIDTH-1:0]   stage_out [SHAMT_W];
   logic [SHAMT_W-1:0] lower_mask;
   logic               last_stage;

   for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
      shift_stage_n #(
         .WIDTH (WIDTH),
         .N     (1 << i)
      ) u_stage (
         .data_i (acc_q),
         .en_i   (shamt_q[i]),
         .op_i   (op_q),
         .data_o (stage_out[i])
      );
   end

   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (STG_W'(i) == stage_q) acc_d = stage_out[i];
      end
   end

   // With early exit, the walk ends once no shamt bits below the current stage remain.
   assign lower_mask = (SHAMT_W'(1) << stage_q) - SHAMT_W'(1);
   assign last_stage = (stage_q == '0) ||
                       ((EARLY_EXIT != 0) && ((shamt_q & lower_mask) == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         shamt_q  <= '0;
         op_q     <= '0;
         stage_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_q   <= data_in;
                  shamt_q <= shamt;
                  op_q    <= op;
                  stage_q <= STG_W'(SHAMT_W - 1);
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               acc_q <= acc_d;
               if (last_stage) begin
                  stage_q  <= '0;
                  result_q <= acc_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  stage_q <= stage_q - STG_W'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: one instance with full-length walks,
// one with early exit, sharing operand inputs but strobed separately.
module tb_shift_sequencer;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy0, done0, busy1, done1;
   logic [31:0] result0, result1;
   seq_state_e  st0, st1;
   logic        sel;

   int checks = 0;
   int errors = 0;

   wire        cur_busy   = sel ? busy1 : busy0;
   wire        cur_done   = sel ? done1 : done0;
   wire [31:0] cur_result = sel ? result1 : result0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .op(op), .data_in(data_in),
      .shamt(shamt), .busy(busy0), .done(done0), .result(result0), .state_dbg(st0)
   );

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op(op), .data_in(data_in),
      .shamt(shamt), .busy(busy1), .done(done1), .result(result1), .state_dbg(st1)
   );

   typedef struct {
      logic        s;
      logic [1:0]  o;
      logic [31:0] d;
      logic [4:0]  sh;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic run_vec(input int idx, input logic s, input logic [1:0] o,
                          input logic [31:0] d, input logic [4:0] sh,
                          input logic [31:0] exp, input int lat_exp);
      int lat;
      int busy_n;
      bit got;
      @(negedge clk);
      sel = s; op = o; data_in = d; shamt = sh;
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      data_in = ~d; shamt = ~sh; op = ~o;
      lat = 0; busy_n = 0; got = 0;
      while (!got && lat < 20) begin
         if (cur_busy) busy_n++;
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (cur_done) got = 1;
      end
      chk($sformatf("v%0d_result", idx), cur_result, exp);
      chk($sformatf("v%0d_latency", idx), lat, lat_exp);
      chk($sformatf("v%0d_busy_cycles", idx), busy_n, lat_exp);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse_width", idx), {31'd0, cur_done}, 32'd0);
      chk($sformatf("v%0d_result_held", idx), cur_result, exp);
   endtask

   initial begin
      int dn;
      int done_at;

      vecs[0]  = '{1'b0, SH_SRL, 32'h8000_0000, 5'd16, 32'h0000_8000, 5};
      vecs[1]  = '{1'b0, SH_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000, 5};
      vecs[2]  = '{1'b0, SH_SRA, 32'h7000_0000, 5'd31, 32'h0000_0000, 5};
      vecs[3]  = '{1'b0, SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 5};
      vecs[4]  = '{1'b0, SH_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 5};
      vecs[5]  = '{1'b0, SH_ROR, 32'h1234_5678, 5'd0,  32'h1234_5678, 5};
      vecs[6]  = '{1'b0, SH_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 5};
      vecs[7]  = '{1'b0, SH_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5};
      vecs[8]  = '{1'b1, SH_SLL, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1};
      vecs[9]  = '{1'b1, SH_SRL, 32'hABCD_0000, 5'd16, 32'h0000_ABCD, 1};
      vecs[10] = '{1'b1, SH_SLL, 32'h0000_0003, 5'd1,  32'h0000_0006, 5};
      vecs[11] = '{1'b1, SH_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000, 3};
      vecs[12] = '{1'b1, SH_ROR, 32'h0000_000F, 5'd6,  32'h3C00_0000, 4};
      vecs[13] = '{1'b0, SH_SLL, 32'h0000_FFFF, 5'd20, 32'hFFF0_0000, 5};

      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
      op = 2'b00; data_in = 32'h0; shamt = 5'd0;
      #1;
      chk("reset_busy",   {30'd0, busy1, busy0}, 32'd0);
      chk("reset_done",   {30'd0, done1, done0}, 32'd0);
      chk("reset_result", result0 | result1, 32'd0);
      chk("reset_state",  {30'd0, st1 == SHIFT, st0 == SHIFT}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         run_vec(i, vecs[i].s, vecs[i].o, vecs[i].d, vecs[i].sh, vecs[i].exp, vecs[i].lat);

      // Starts while busy are ignored; a start in the done cycle is accepted.
      sel = 1'b0; dn = 0;
      @(negedge clk);
      op = SH_SLL; data_in = 32'h0000_0003; shamt = 5'd4; start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0; op = SH_ROR; data_in = 32'h0000_FFFF; shamt = 5'd1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done0) dn++;
         start0 = (c <= 3);
      end
      chk("busy_start_done_at_5", {31'd0, done0}, 32'd1);
      chk("busy_start_done_count", dn, 1);
      chk("busy_start_result", result0, 32'h0000_0030);
      op = SH_SRL; data_in = 32'h0000_0080; shamt = 5'd3; start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      dn = 0; done_at = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done0) begin dn++; done_at = c; end
      end
      chk("done_cycle_start_count", dn, 1);
      chk("done_cycle_start_latency", done_at, 5);
      chk("done_cycle_start_result", result0, 32'h0000_0010);

      // Asynchronous reset during the third SHIFT cycle aborts the request.
      @(negedge clk);
      op = SH_SRL; data_in = 32'hFFFF_FFFF; shamt = 5'd8; start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy",   {31'd0, busy0}, 32'd0);
      chk("abort_done",   {31'd0, done0}, 32'd0);
      chk("abort_result", result0, 32'd0);
      chk("abort_state",  {31'd0, st0 == SHIFT}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done0 || busy0) dn++;
      end
      chk("abort_no_late_done", dn, 0);
      chk("abort_result_still_zero", result0, 32'd0);
      run_vec(99, 1'b0, SH_SRL, 32'hFFFF_FFFF, 5'd8, 32'h00FF_FFFF, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
